// File: rtl/mul_arbiter_pkg.sv
// Shared datapath types for the two-requester multiplier arbiter.
package mul_arbiter_pkg;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [N_REQ-1:0]  req_vec_t;
    typedef logic [0:0]        tag_t;

    // Requester index to its one-hot position in a per-requester vector.
    function automatic req_vec_t tag_to_onehot(input tag_t tag);
        req_vec_t v;
        v = '0;
        v[tag] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Request/response bus between the requesters and the multiplier arbiter.
interface mul_arbiter_if;
    import mul_arbiter_pkg::*;

    req_vec_t req_valid;
    req_vec_t req_ready;
    data_t    req0_a;
    data_t    req0_b;
    data_t    req1_a;
    data_t    req1_b;
    req_vec_t rsp_valid;
    data_t    rsp_data;
    logic     busy;
    data_t    op_count;

    modport master (
        output req_valid, req0_a, req0_b, req1_a, req1_b,
        input  req_ready, rsp_valid, rsp_data, busy, op_count
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req1_a, req1_b,
        output req_ready, rsp_valid, rsp_data, busy, op_count
    );

endinterface

// File: rtl/mul_arbiter_mul_pipe.sv
// Fixed-latency multiplier pipeline; each stage carries valid, requester
// tag and product. Stage payloads only move when a valid entry moves into
// them, so the output payload holds its last valid value across bubbles.
module mul_pipe
    import mul_arbiter_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  tag_t  in_tag,
    input  data_t in_a,
    input  data_t in_b,
    output logic  out_valid,
    output tag_t  out_tag,
    output data_t out_data,
    output logic  in_flight
);

    logic  vld_q  [LATENCY];
    logic  vld_d  [LATENCY];
    tag_t  tag_q  [LATENCY];
    tag_t  tag_d  [LATENCY];
    data_t prod_q [LATENCY];
    data_t prod_d [LATENCY];
    logic  in_flight_c;

    // Next-stage contents: shift valid every cycle, payload only with valid.
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            vld_d[i]  = 1'b0;
            tag_d[i]  = tag_q[i];
            prod_d[i] = prod_q[i];
        end
        vld_d[0] = in_valid;
        if (in_valid) begin
            tag_d[0]  = in_tag;
            prod_d[0] = in_a * in_b;
        end
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                tag_d[i]  = tag_q[i-1];
                prod_d[i] = prod_q[i-1];
            end
        end
    end

    // Any stage occupied means an operation is still in flight.
    always_comb begin
        in_flight_c = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            in_flight_c = in_flight_c | vld_q[i];
        end
    end

    // Stage registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i]  <= 1'b0;
                tag_q[i]  <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i]  <= vld_d[i];
                tag_q[i]  <= tag_d[i];
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign out_data  = prod_q[LATENCY-1];
    assign in_flight = in_flight_c;

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester round-robin arbiter in front of a pipelined 32x32 multiplier.
// No response backpressure: any valid request is granted the same cycle.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int LATENCY  = 2,
    parameter int RR_RESET = 0
) (
    input  logic          clk,
    input  logic          rst,
    mul_arbiter_if.slave  bus
);

    tag_t  prio_q, prio_d;
    data_t op_count_q, op_count_d;

    logic  grant_vld;
    tag_t  grant_id;
    data_t op_a;
    data_t op_b;

    logic  pipe_valid;
    tag_t  pipe_tag;
    data_t pipe_data;
    logic  pipe_in_flight;

    // Grant selection, operand mux, priority and counter next-state.
    always_comb begin
        grant_vld  = 1'b0;
        grant_id   = prio_q;
        prio_d     = prio_q;
        op_count_d = op_count_q;
        if (!rst) begin
            case (bus.req_valid)
                2'b01: begin grant_vld = 1'b1; grant_id = 1'b0;   end
                2'b10: begin grant_vld = 1'b1; grant_id = 1'b1;   end
                2'b11: begin grant_vld = 1'b1; grant_id = prio_q; end
                default: ;
            endcase
        end
        if (grant_vld) begin
            prio_d     = ~grant_id;
            op_count_d = op_count_q + 32'd1;
        end
        op_a = (grant_id == 1'b0) ? bus.req0_a : bus.req1_a;
        op_b = (grant_id == 1'b0) ? bus.req0_b : bus.req1_b;
    end

    // Priority pointer and accepted-operation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= tag_t'(RR_RESET);
            op_count_q <= '0;
        end else begin
            prio_q     <= prio_d;
            op_count_q <= op_count_d;
        end
    end

    mul_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (grant_vld),
        .in_tag    (grant_id),
        .in_a      (op_a),
        .in_b      (op_b),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_data  (pipe_data),
        .in_flight (pipe_in_flight)
    );

    assign bus.req_ready = grant_vld ? tag_to_onehot(grant_id) : '0;
    assign bus.rsp_valid = pipe_valid ? tag_to_onehot(pipe_tag) : '0;
    assign bus.rsp_data  = pipe_data;
    assign bus.busy      = pipe_in_flight;
    assign bus.op_count  = op_count_q;

endmodule
